// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the alu_sched block.
// ALU/condition encodings, CC bit positions and reset values.
package alu_sched_pkg;

   localparam int DATA_W = 64;

   typedef enum logic [1:0] {
      FUN_ADD = 2'd0,
      FUN_SUB = 2'd1,
      FUN_AND = 2'd2,
      FUN_XOR = 2'd3
   } alu_fun_e;

   typedef enum logic [2:0] {
      C_ALWAYS = 3'd0,
      C_LE     = 3'd1,
      C_L      = 3'd2,
      C_E      = 3'd3,
      C_NE     = 3'd4,
      C_GE     = 3'd5,
      C_G      = 3'd6,
      C_NEVER  = 3'd7
   } cond_e;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } rsp_state_e;

   localparam int CC_ZF = 2;
   localparam int CC_SF = 1;
   localparam int CC_OF = 0;

   localparam logic [2:0] CC_RST = 3'b100;

   typedef struct packed {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [1:0]        fun;
      logic              setcc;
      logic              id;
   } issue_t;

endpackage

// File: rtl/alu_sched_if.sv
// Request and response handshake bundles for alu_sched.
// Master drives the payload, slave returns ready.
interface alu_sched_req_if;
   import alu_sched_pkg::*;

   logic              valid;
   logic              ready;
   logic [DATA_W-1:0] a;
   logic [DATA_W-1:0] b;
   logic [1:0]        fun;
   logic              setcc;

   modport master (
      output valid, a, b, fun, setcc,
      input  ready
   );

   modport slave (
      input  valid, a, b, fun, setcc,
      output ready
   );
endinterface

interface alu_sched_rsp_if;
   import alu_sched_pkg::*;

   logic              valid;
   logic              ready;
   logic              id;
   logic [DATA_W-1:0] vale;
   logic [2:0]        cc;

   modport master (
      output valid, id, vale, cc,
      input  ready
   );

   modport slave (
      input  valid, id, vale, cc,
      output ready
   );
endinterface

// File: rtl/alu.sv
// Shared 64-bit ALU: computes B op A and its {ZF,SF,OF} flags.
// OF is signed overflow for add/sub, zero for logic ops.
module alu
   import alu_sched_pkg::*;
#(
   parameter int W = 64
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic [1:0]   i_fun,
   output logic [W-1:0] o_vale,
   output logic [2:0]   o_cc
);

   alu_fun_e     w_fun;
   logic [W-1:0] w_res;
   logic         w_of;

   assign w_fun = alu_fun_e'(i_fun);

   always_comb begin
      w_res = '0;
      w_of  = 1'b0;
      unique case (w_fun)
         FUN_ADD: begin
            w_res = i_b + i_a;
            w_of  = (i_a[W-1] == i_b[W-1]) &&
                    (w_res[W-1] != i_b[W-1]);
         end
         FUN_SUB: begin
            w_res = i_b - i_a;
            w_of  = (i_a[W-1] != i_b[W-1]) &&
                    (w_res[W-1] != i_b[W-1]);
         end
         FUN_AND: w_res = i_b & i_a;
         FUN_XOR: w_res = i_b ^ i_a;
         default: w_res = '0;
      endcase
   end

   always_comb begin
      o_cc        = '0;
      o_cc[CC_ZF] = (w_res == '0);
      o_cc[CC_SF] = w_res[W-1];
      o_cc[CC_OF] = w_of;
   end

   assign o_vale = w_res;

endmodule

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter with its last-grant register.
// Grant is a pure function of requests and history.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] i_req,
   input  logic       i_adv,
   output logic       o_gnt
);

   logic r_last;

   always_comb begin
      o_gnt = 1'b0;
      unique case (1'b1)
         (i_req == 2'b11): o_gnt = ~r_last;
         (i_req == 2'b10): o_gnt = 1'b1;
         default:          o_gnt = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_last <= 1'b1;
      else if (i_adv)
         r_last <= o_gnt;
   end

endmodule

// File: rtl/alu_sched.sv
// Two-port round-robin front end for the shared ALU, with a
// one-entry response buffer and the architectural CC register.
module alu_sched
   import alu_sched_pkg::*;
#(
   parameter int W = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   alu_sched_req_if.slave        req0,
   alu_sched_req_if.slave        req1,
   alu_sched_rsp_if.master       rsp,
   output logic [2:0]            cc_q,
   input  logic [2:0]            cond_fun,
   output logic                  cond
);

   rsp_state_e   r_state;
   rsp_state_e   w_next;
   logic         w_space;
   logic         w_gnt;
   logic         w_acc;
   issue_t       w_iss;
   logic [W-1:0] w_vale;
   logic [2:0]   w_cc;
   logic         r_id;
   logic [W-1:0] r_vale;
   logic [2:0]   r_rcc;
   logic [2:0]   r_ccq;
   logic         w_lt;
   cond_e        w_cf;

   rr_arb2 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .i_req ({req1.valid, req0.valid}),
      .i_adv (w_acc),
      .o_gnt (w_gnt)
   );

   assign w_space    = (r_state == ST_EMPTY) || rsp.ready;
   assign req0.ready = w_space && !w_gnt;
   assign req1.ready = w_space && w_gnt;
   assign w_acc      = (req0.valid && req0.ready) ||
                       (req1.valid && req1.ready);

   always_comb begin
      w_iss.a     = req0.a;
      w_iss.b     = req0.b;
      w_iss.fun   = req0.fun;
      w_iss.setcc = req0.setcc;
      w_iss.id    = 1'b0;
      if (w_gnt) begin
         w_iss.a     = req1.a;
         w_iss.b     = req1.b;
         w_iss.fun   = req1.fun;
         w_iss.setcc = req1.setcc;
         w_iss.id    = 1'b1;
      end
   end

   alu #(.W(W)) u_alu (
      .i_a    (w_iss.a),
      .i_b    (w_iss.b),
      .i_fun  (w_iss.fun),
      .o_vale (w_vale),
      .o_cc   (w_cc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= ST_EMPTY;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_EMPTY: if (w_acc) w_next = ST_FULL;
         ST_FULL: begin
            if (w_acc)
               w_next = ST_FULL;
            else if (rsp.ready)
               w_next = ST_EMPTY;
         end
         default: w_next = ST_EMPTY;
      endcase
   end

   always_comb begin
      rsp.valid = (r_state == ST_FULL);
      rsp.id    = r_id;
      rsp.vale  = r_vale;
      rsp.cc    = r_rcc;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_id   <= 1'b0;
         r_vale <= '0;
         r_rcc  <= '0;
      end else if (w_acc) begin
         r_id   <= w_iss.id;
         r_vale <= w_vale;
         r_rcc  <= w_cc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_ccq <= CC_RST;
      else if (w_acc && w_iss.setcc)
         r_ccq <= w_cc;
   end

   assign cc_q = r_ccq;
   assign w_lt = r_ccq[CC_SF] ^ r_ccq[CC_OF];
   assign w_cf = cond_e'(cond_fun);

   always_comb begin
      cond = 1'b0;
      unique case (w_cf)
         C_ALWAYS: cond = 1'b1;
         C_LE:     cond = w_lt | r_ccq[CC_ZF];
         C_L:      cond = w_lt;
         C_E:      cond = r_ccq[CC_ZF];
         C_NE:     cond = !r_ccq[CC_ZF];
         C_GE:     cond = !w_lt;
         C_G:      cond = !w_lt && !r_ccq[CC_ZF];
         C_NEVER:  cond = 1'b0;
         default:  cond = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_alu_sched.sv
// Directed self-checking bench for alu_sched.
// Inputs change on negedge; outputs sampled on negedge or mid-cycle.
module tb_alu_sched;
   import alu_sched_pkg::*;

   logic       clk;
   logic       rst_n;
   logic [2:0] cc_q;
   logic [2:0] cond_fun;
   logic       cond;
   int         n_vec;
   int         n_err;

   alu_sched_req_if u_r0 ();
   alu_sched_req_if u_r1 ();
   alu_sched_rsp_if u_rs ();

   alu_sched #(.W(64)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req0     (u_r0.slave),
      .req1     (u_r1.slave),
      .rsp      (u_rs.master),
      .cc_q     (cc_q),
      .cond_fun (cond_fun),
      .cond     (cond)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      u_r0.valid = 1'b0; u_r0.a = '0; u_r0.b = '0;
      u_r0.fun = 2'd0;   u_r0.setcc = 1'b0;
      u_r1.valid = 1'b0; u_r1.a = '0; u_r1.b = '0;
      u_r1.fun = 2'd0;   u_r1.setcc = 1'b0;
      u_rs.ready = 1'b1;
      cond_fun = 3'd3;
      repeat (2) @(negedge clk);
      n_vec++;
      if (u_rs.valid !== 1'b0) begin
         n_err++;
         $display("FAIL rst_valid got %b want 0", u_rs.valid);
      end
      n_vec++;
      if (cc_q !== 3'b100) begin
         n_err++;
         $display("FAIL rst_ccq got %b want 100", cc_q);
      end
      n_vec++;
      if (u_rs.vale !== 64'd0 || u_rs.cc !== 3'b000 ||
          u_rs.id !== 1'b0) begin
         n_err++;
         $display("FAIL rst_rsp got id%b %h %b want 0 0 000",
                  u_rs.id, u_rs.vale, u_rs.cc);
      end
      n_vec++;
      if (cond !== 1'b1) begin
         n_err++;
         $display("FAIL rst_cond_e got %b want 1", cond);
      end
      cond_fun = 3'd4;
      #1;
      n_vec++;
      if (cond !== 1'b0) begin
         n_err++;
         $display("FAIL rst_cond_ne got %b want 0", cond);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single_add();
      @(negedge clk);
      u_r0.valid = 1'b1; u_r0.a = 64'd5; u_r0.b = 64'd3;
      u_r0.fun = 2'd0;   u_r0.setcc = 1'b1;
      #1;
      n_vec++;
      if (u_r0.ready !== 1'b1 || u_r1.ready !== 1'b0) begin
         n_err++;
         $display("FAIL add_ready got %b%b want 10",
                  u_r0.ready, u_r1.ready);
      end
      @(negedge clk);
      u_r0.valid = 1'b0;
      n_vec++;
      if (u_rs.valid !== 1'b1 || u_rs.id !== 1'b0 ||
          u_rs.vale !== 64'd8 || u_rs.cc !== 3'b000) begin
         n_err++;
         $display("FAIL add_rsp got v%b id%b %0d %b want 1 0 8 000",
                  u_rs.valid, u_rs.id, u_rs.vale, u_rs.cc);
      end
      n_vec++;
      if (cc_q !== 3'b000) begin
         n_err++;
         $display("FAIL add_ccq got %b want 000", cc_q);
      end
      @(negedge clk);
      n_vec++;
      if (u_rs.valid !== 1'b0) begin
         n_err++;
         $display("FAIL add_drain got %b want 0", u_rs.valid);
      end
   endtask

   task automatic test_contention();
      logic [63:0] exp_v [2];
      exp_v[0] = 64'd11;
      exp_v[1] = 64'd18;
      do_reset();
      u_r0.a = 64'd1; u_r0.b = 64'd10; u_r0.fun = 2'd0;
      u_r0.setcc = 1'b0;
      u_r1.a = 64'd2; u_r1.b = 64'd20; u_r1.fun = 2'd1;
      u_r1.setcc = 1'b0;
      u_rs.ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) begin
            n_vec++;
            if (u_rs.valid !== 1'b1 ||
                u_rs.id !== 1'((i - 1) % 2) ||
                u_rs.vale !== exp_v[(i - 1) % 2]) begin
               n_err++;
               $display("FAIL cont_rsp%0d got v%b id%b %0d want 1 %0d %0d",
                        i, u_rs.valid, u_rs.id, u_rs.vale,
                        (i - 1) % 2, exp_v[(i - 1) % 2]);
            end
         end
         if (i < 4) begin
            u_r0.valid = 1'b1;
            u_r1.valid = 1'b1;
            #1;
            n_vec++;
            if (u_r0.ready !== 1'((i + 1) % 2) ||
                u_r1.ready !== 1'(i % 2)) begin
               n_err++;
               $display("FAIL cont_gnt%0d got %b%b want %0d%0d",
                        i, u_r0.ready, u_r1.ready,
                        (i + 1) % 2, i % 2);
            end
            @(negedge clk);
         end
      end
      u_rs.ready = 1'b0;
      n_vec++;
      if (cc_q !== 3'b100) begin
         n_err++;
         $display("FAIL cont_ccq got %b want 100", cc_q);
      end
   endtask

   task automatic test_backpressure();
      for (int k = 0; k < 3; k++) begin
         #1;
         n_vec++;
         if (u_r0.ready !== 1'b0 || u_r1.ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_ready%0d got %b%b want 00",
                     k, u_r0.ready, u_r1.ready);
         end
         @(negedge clk);
         n_vec++;
         if (u_rs.valid !== 1'b1 || u_rs.id !== 1'b1 ||
             u_rs.vale !== 64'd18 || cc_q !== 3'b100) begin
            n_err++;
            $display("FAIL bp_hold%0d got v%b id%b %0d cc%b want 1 1 18 100",
                     k, u_rs.valid, u_rs.id, u_rs.vale, cc_q);
         end
      end
      u_rs.ready = 1'b1;
      #1;
      n_vec++;
      if (u_r0.ready !== 1'b1 || u_r1.ready !== 1'b0) begin
         n_err++;
         $display("FAIL bp_release got %b%b want 10",
                  u_r0.ready, u_r1.ready);
      end
      @(negedge clk);
      u_r0.valid = 1'b0;
      u_r1.valid = 1'b0;
      n_vec++;
      if (u_rs.id !== 1'b0 || u_rs.vale !== 64'd11) begin
         n_err++;
         $display("FAIL bp_next got id%b %0d want 0 11",
                  u_rs.id, u_rs.vale);
      end
      @(negedge clk);
      n_vec++;
      if (u_rs.valid !== 1'b0) begin
         n_err++;
         $display("FAIL bp_drain got %b want 0", u_rs.valid);
      end
   endtask

   task automatic test_overflow_cond();
      logic [2:0] fsel [6];
      logic       fexp [6];
      fsel = '{3'd2, 3'd1, 3'd6, 3'd5, 3'd0, 3'd7};
      fexp = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      u_r1.valid = 1'b1;
      u_r1.a = 64'h7FFF_FFFF_FFFF_FFFF;
      u_r1.b = 64'd1;
      u_r1.fun = 2'd0;
      u_r1.setcc = 1'b1;
      #1;
      n_vec++;
      if (u_r1.ready !== 1'b1) begin
         n_err++;
         $display("FAIL ovf_ready got %b want 1", u_r1.ready);
      end
      @(negedge clk);
      u_r1.valid = 1'b0;
      n_vec++;
      if (u_rs.vale !== 64'h8000_0000_0000_0000 ||
          u_rs.id !== 1'b1 || u_rs.cc !== 3'b011) begin
         n_err++;
         $display("FAIL ovf_rsp got id%b %h %b want 1 8000000000000000 011",
                  u_rs.id, u_rs.vale, u_rs.cc);
      end
      n_vec++;
      if (cc_q !== 3'b011) begin
         n_err++;
         $display("FAIL ovf_ccq got %b want 011", cc_q);
      end
      for (int j = 0; j < 6; j++) begin
         cond_fun = fsel[j];
         #1;
         n_vec++;
         if (cond !== fexp[j]) begin
            n_err++;
            $display("FAIL ovf_cond%0d got %b want %b",
                     fsel[j], cond, fexp[j]);
         end
      end
   endtask

   task automatic test_setcc0_reset();
      @(negedge clk);
      u_r0.valid = 1'b1;
      u_r0.a = 64'hDEAD_BEEF_0123_4567;
      u_r0.b = 64'hDEAD_BEEF_0123_4567;
      u_r0.fun = 2'd3;
      u_r0.setcc = 1'b0;
      @(negedge clk);
      u_r0.valid = 1'b0;
      u_rs.ready = 1'b0;
      n_vec++;
      if (u_rs.valid !== 1'b1 || u_rs.vale !== 64'd0 ||
          u_rs.cc !== 3'b100) begin
         n_err++;
         $display("FAIL xor_rsp got v%b %h %b want 1 0 100",
                  u_rs.valid, u_rs.vale, u_rs.cc);
      end
      n_vec++;
      if (cc_q !== 3'b011) begin
         n_err++;
         $display("FAIL xor_ccq got %b want 011", cc_q);
      end
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (u_rs.valid !== 1'b0 || cc_q !== 3'b100) begin
         n_err++;
         $display("FAIL async_rst got v%b cc%b want 0 100",
                  u_rs.valid, cc_q);
      end
      @(negedge clk);
      rst_n = 1'b1;
      u_rs.ready = 1'b1;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      test_reset();
      test_single_add();
      test_contention();
      test_backpressure();
      test_overflow_cond();
      test_setcc0_reset();
      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule
